// File: rtl/nios2_status_input.sv
// Avalon-MM status input port: synchronizes an external status bus, captures
// rising edges per bit into W1C sticky flags and raises a masked level IRQ.
module nios2_status_input #(
  parameter int unsigned      WIDTH      = 16,
  parameter logic [WIDTH-1:0] RESET_MASK = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  logic [WIDTH-1:0]  sync1_q, sync1_d;
  logic [WIDTH-1:0]  sync2_q, sync2_d;
  logic [WIDTH-1:0]  prev_q, prev_d;
  logic [WIDTH-1:0]  edge_capture_q, edge_capture_d;
  logic [WIDTH-1:0]  irq_mask_q, irq_mask_d;
  logic [DATA_W-1:0] readdata_q, readdata_d;

  logic             wr_en;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] wdata;

  if (WIDTH < DATA_W) begin : g_wdata_hi
    logic unused_wdata_hi;
    assign unused_wdata_hi = ^writedata[DATA_W-1:WIDTH];
  end

  // Next-state logic for synchronizer, edge capture, mask and read mux
  always_comb begin
    wr_en          = chipselect && !write_n;
    wdata          = writedata[WIDTH-1:0];
    sync1_d        = in_port;
    sync2_d        = sync1_q;
    prev_d         = sync2_q;
    irq_mask_d     = irq_mask_q;
    readdata_d     = '0;
    clr            = '0;
    rise           = sync2_q & ~prev_q;

    if (wr_en && (address == ADDR_MASK)) irq_mask_d = wdata;
    if (wr_en && (address == ADDR_EDGE)) clr = wdata;

    // A new edge beats a simultaneous clear of the same bit
    edge_capture_d = (edge_capture_q & ~clr) | rise;

    case (address)
      ADDR_DATA: readdata_d = DATA_W'(sync2_q);
      ADDR_MASK: readdata_d = DATA_W'(irq_mask_q);
      ADDR_EDGE: readdata_d = DATA_W'(edge_capture_q);
      default:   readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q        <= '0;
      sync2_q        <= '0;
      prev_q         <= '0;
      edge_capture_q <= '0;
      irq_mask_q     <= RESET_MASK;
      readdata_q     <= '0;
    end else begin
      sync1_q        <= sync1_d;
      sync2_q        <= sync2_d;
      prev_q         <= prev_d;
      edge_capture_q <= edge_capture_d;
      irq_mask_q     <= irq_mask_d;
      readdata_q     <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(edge_capture_q & irq_mask_q);

endmodule

// File: tb/tb_nios2_status_input.sv
// Self-checking bench for nios2_status_input: directed table, hand-built
// corner sequences, then random traffic against a delay-line reference model.
module tb_nios2_status_input;

  localparam int unsigned W = 16;
  localparam logic [W-1:0] RST_MASK = '0;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [W-1:0] in_port = '0;
  logic        irq;

  int n_cmp = 0;
  int n_bad = 0;

  nios2_status_input #(.WIDTH(W), .RESET_MASK(RST_MASK)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .irq(irq)
  );

  always #5 clk = ~clk;

  // Reference model: in_port samples kept in a queue (newest first); the
  // register state follows the programmer-visible rules directly.
  logic [W-1:0]  hist[$];
  logic [W-1:0]  m_cap, m_mask;
  logic [31:0]   m_rd;
  logic [W-1:0]  m_clr;

  initial begin
    hist = '{16'h0, 16'h0, 16'h0};
    m_cap = '0; m_mask = RST_MASK; m_rd = '0;
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist = '{16'h0, 16'h0, 16'h0};
      m_cap = '0; m_mask = RST_MASK; m_rd = '0;
    end else begin
      // hist[1] is the value DATA shows; hist[1] high and hist[2] low is an edge
      case (address)
        2'd0: m_rd = 32'(hist[1]);
        2'd2: m_rd = 32'(m_mask);
        2'd3: m_rd = 32'(m_cap);
        default: m_rd = 32'h0;
      endcase
      m_clr = (chipselect && !write_n && address == 2'd3) ? writedata[W-1:0] : '0;
      if (chipselect && !write_n && address == 2'd2) m_mask = writedata[W-1:0];
      m_cap = (m_cap & ~m_clr) | (hist[1] & ~hist[2]);
      hist.push_front(in_port);
      void'(hist.pop_back());
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    @(posedge clk); @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    address = a;
    @(posedge clk); @(negedge clk);
    d = readdata;
  endtask

  typedef struct {
    logic [W-1:0] pins;
    logic [1:0]   addr;
    logic [31:0]  exp_rd;
  } vec_t;

  vec_t vecs[6];
  logic [31:0] rd;

  initial begin
    vecs[0] = '{16'hA5C3, 2'd0, 32'h0000A5C3};
    vecs[1] = '{16'hA5C3, 2'd1, 32'h00000000};
    vecs[2] = '{16'hFFFF, 2'd0, 32'h0000FFFF};
    vecs[3] = '{16'h0000, 2'd0, 32'h00000000};
    vecs[4] = '{16'h1234, 2'd2, 32'h00000000};
    vecs[5] = '{16'h8001, 2'd0, 32'h00008001};

    // Reset with inputs already high; power-on edge expected after release
    in_port = 16'hFFFF;
    tick(3);
    check("reset_readdata", readdata, 32'h0);
    check("reset_irq", 32'(irq), 32'h0);
    reset_n = 1'b1;
    tick(4);
    bus_read(2'd3, rd);
    check("poweron_capture", rd, 32'h0000FFFF);
    bus_write(2'd3, 32'h0000FFFF);
    bus_read(2'd3, rd);
    check("w1c_all", rd, 32'h0);

    // Data register table, with writes to read-only/reserved words in between
    for (int i = 0; i < 6; i++) begin
      in_port = vecs[i].pins;
      bus_write(2'd1, 32'hFFFFFFFF);
      bus_write(2'd0, 32'h0000FFFF);
      tick(1);
      bus_read(vecs[i].addr, rd);
      check($sformatf("table_%0d", i), rd, vecs[i].exp_rd);
    end

    // Edge and IRQ timing
    in_port = '0;
    tick(4);
    bus_write(2'd3, 32'h0000FFFF);
    bus_write(2'd2, 32'h00000001);
    check("irq_idle", 32'(irq), 32'h0);
    in_port = 16'h0001;
    tick(2);
    check("irq_edge2", 32'(irq), 32'h0);
    tick(1);
    check("irq_edge3", 32'(irq), 32'h1);
    in_port = 16'h0011;
    tick(4);
    check("irq_hold", 32'(irq), 32'h1);
    bus_read(2'd3, rd);
    check("cap_0011", rd, 32'h00000011);
    bus_write(2'd3, 32'h00000001);
    check("irq_after_clr", 32'(irq), 32'h0);
    bus_read(2'd3, rd);
    check("cap_0010", rd, 32'h00000010);

    // Masking
    bus_write(2'd2, 32'h0);
    check("irq_mask0", 32'(irq), 32'h0);
    bus_write(2'd2, 32'h00000010);
    check("irq_mask10", 32'(irq), 32'h1);

    // W1C of bit 2 sampled on the same edge that captures a bit-2 edge
    in_port = 16'h0015;
    tick(2);
    bus_write(2'd3, 32'h00000004);
    bus_read(2'd3, rd);
    check("set_wins", rd, 32'h00000014);

    // Falling edges leave capture alone; writes to 0/1 do nothing
    in_port = '0;
    tick(5);
    bus_write(2'd0, 32'hFFFFFFFF);
    bus_write(2'd1, 32'hFFFFFFFF);
    bus_read(2'd3, rd);
    check("falling_ignored", rd, 32'h00000014);
    bus_read(2'd2, rd);
    check("mask_kept", rd, 32'h00000010);
    check("irq_before_rst", 32'(irq), 32'h1);

    // Asynchronous reset mid-operation
    address = 2'd3;
    #3 reset_n = 1'b0;
    #1;
    check("async_rst_irq", 32'(irq), 32'h0);
    check("async_rst_rd", readdata, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    bus_read(2'd2, rd);
    check("mask_reset", rd, 32'(RST_MASK));
    bus_read(2'd3, rd);
    check("cap_reset", rd, 32'h0);

    // Random traffic against the reference model
    for (int c = 0; c < 3000; c++) begin
      check("rand_rd", readdata, m_rd);
      check("rand_irq", 32'(irq), 32'(|(m_cap & m_mask)));
      if (c == 1500) begin
        reset_n = 1'b0;
        #1;
        check("rand_rst_irq", 32'(irq), 32'h0);
      end else begin
        reset_n = 1'b1;
      end
      if ($urandom_range(3) == 0) in_port = in_port ^ W'($urandom);
      address    = 2'($urandom_range(3));
      chipselect = 1'($urandom_range(1));
      write_n    = ($urandom_range(3) != 0);
      writedata  = $urandom;
      @(negedge clk);
    end
    chipselect = 1'b0; write_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/nios2_status_input.md
# nios2_status_input

Avalon-MM slave input port for the Nios II system: the read-side counterpart of the 16-bit output register ports on the same bus. It synchronizes a 16-bit external status bus, latches rising edges per bit into a sticky edge-capture register, and raises a level interrupt for captured edges whose mask bit is set. Software polls the data register or services the IRQ, then clears the handled edge bits with write-1-to-clear.

## Interface
Parameters:
- WIDTH, 16, width of in_port and of the data, mask and capture registers (1..32)
- RESET_MASK, 0, reset value of the interrupt mask register

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous, active-low reset
- address  input  2  register word select
- chipselect  input  1  slave select
- write_n  input  1  active-low write strobe, qualified by chipselect
- writedata  input  32  write data; bits above WIDTH-1 ignored
- readdata  output  32  registered read data, zero-extended above WIDTH-1
- in_port  input  WIDTH  asynchronous external status inputs
- irq  output  1  level interrupt, active high

## Operation
- Register map, word addresses:
  - 0 DATA (RO): synchronized in_port value
  - 1 reserved: reads 0, writes ignored
  - 2 IRQ_MASK (RW): per-bit interrupt enable
  - 3 EDGE_CAPTURE (R/W1C): sticky rising-edge flags
- Input path: two-flop synchronizer (sync1, sync2), then one history flop (prev). Rising edge on bit i when sync2[i]=1 and prev[i]=0. Falling edges are ignored.
- Edge capture, per bit:
  - Set when an edge is detected.
  - Cleared when chipselect && !write_n && address==3 && writedata[i]==1.
  - An edge in the same cycle as a clear of that bit: set wins, bit stays 1.
- IRQ_MASK is written by chipselect && !write_n && address==2.
- irq = |(edge_capture & irq_mask), decoded combinationally from registers with no extra flop.
- Reads have no side effects. A read of EDGE_CAPTURE does not clear it.
- Writes to address 0 or 1 have no effect.
- Reset values:
  - sync1, sync2, prev, edge_capture: 0
  - irq_mask: RESET_MASK
  - readdata: 0
  - irq: 0 when RESET_MASK is 0
- Because prev resets to 0, an input that is already high when reset releases produces one capture about 3 cycles later. This is intended.
- Reset asserted mid-operation clears all state immediately and asynchronously. irq deasserts in the same instant.

## Timing
- readdata is registered every clock from the current address, with no read strobe. Read latency is 1 cycle: the value for the address presented at edge N is valid after edge N+1.
- in_port change to DATA visible: the change is in sync2 after 2 clock edges. readdata reflects it one edge later when address==0.
- in_port rising to edge_capture set: edge 1 into sync1, edge 2 into sync2, edge 3 sets capture. irq asserts after edge 3 if masked in.
- A write takes effect at the clock edge where it is sampled. irq reflects a mask change or a clear immediately after that edge.
- An input pulse narrower than one clock period may be missed. A pulse high for at least 2 clock periods is always captured.
- No wait states. The slave never stalls the bus.

## Test plan
- Reset: hold reset_n=0 with in_port=16'hFFFF, then release. readdata=0 and irq=0 during reset. edge_capture reads 16'hFFFF after at most 4 cycles (power-on edge). Write 32'hFFFF to address 3, then edge_capture reads 0.
- Data read: drive in_port=16'hA5C3, wait 3 cycles, read address 0. readdata=32'h0000A5C3 one cycle after the address. Read address 1 gives 0.
- Edge and IRQ:
  - Setup: mask=16'h0001, in_port=0.
  - Raise bit 0: irq goes high exactly 3 edges later.
  - Raise bit 4: capture=16'h0011 and irq stays high.
  - Write 16'h0001 to address 3: capture=16'h0010 and irq drops.
- Masking: with capture=16'h0010 and mask=0, irq=0. Write mask=16'h0010: irq rises the cycle after the write.
- Simultaneous set/clear: time a W1C of bit 2 to the cycle in which a bit-2 edge is detected. Bit 2 reads 1 afterwards.
- Falling edges and reset mid-operation:
  - in_port 1 to 0 on any bit leaves capture unchanged.
  - Assert reset_n while irq=1: irq and readdata go to 0 asynchronously, and irq_mask returns to RESET_MASK.
